// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: funct3/size codes, FSM states,
// and helpers for access-size decoding and alignment.
package dmem_pkg;

    localparam int READ_EN_BIT  = 3;
    localparam int WRITE_EN_BIT = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_e;

    // Load funct3[1:0] and store size share one encoding; 11 and unknown codes mean word.
    function automatic size_e decode_size(input logic [1:0] code);
        case (code)
            SZ_B:    return SIZE_BYTE;
            SZ_H:    return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
        case (size)
            SIZE_HALF: return lo[0];
            SIZE_WORD: return |lo;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_low(input size_e size, input logic [1:0] lo);
        case (size)
            SIZE_HALF: return {lo[1], 1'b0};
            SIZE_WORD: return 2'b00;
            default:   return lo;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage data bus between the pipeline (master) and the data-memory controller (slave).
interface dmem_if;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busywait;
    logic        misaligned_err;

    modport master (
        output mem_read, mem_write, address, write_data,
        input  read_data, busywait, misaligned_err
    );

    modport slave (
        input  mem_read, mem_write, address, write_data,
        output read_data, busywait, misaligned_err
    );
endinterface

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half lanes of a stored word and applies RV32 sign/zero extension.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/dmem_controller.sv
// Fixed-latency word-organised data memory with pipeline stall handshake.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses are suppressed and flagged.
module dmem_controller
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   read_data_q;
    logic          misaligned_err_q;
    logic [31:0]   mem_q [DEPTH];

    logic          wr_req, rd_req, req;
    logic          misalign, commit, wr_commit;
    size_e         size;
    logic [1:0]    addr_lo;
    logic [AW-1:0] word_idx;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   load_data;

    assign wr_req   = bus.mem_write[WRITE_EN_BIT];
    assign rd_req   = bus.mem_read[READ_EN_BIT] & ~wr_req;
    assign req      = wr_req | bus.mem_read[READ_EN_BIT];
    assign size     = decode_size(wr_req ? bus.mem_write[1:0] : bus.mem_read[1:0]);
    assign word_idx = bus.address[2 +: AW];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(size, bus.address[1:0]);
    assign addr_lo  = bus.address[1:0];
`else
    assign misalign = 1'b0;
    assign addr_lo  = align_low(size, bus.address[1:0]);
`endif

    always_comb begin
        byte_en  = 4'b1111;
        wr_lanes = bus.write_data;
        case (size)
            SIZE_BYTE: begin
                byte_en  = 4'b0001 << addr_lo;
                wr_lanes = {4{bus.write_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{bus.write_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign commit    = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign wr_commit = commit & wr_req & ~misalign;

    // NOTE: the storage array has no reset; only the control state does, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    dmem_load_align u_load_align (
        .word_i    (mem_q[word_idx]),
        .addr_lo_i (addr_lo),
        .funct3_i  (bus.mem_read[2:0]),
        .data_o    (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            read_data_q      <= '0;
            misaligned_err_q <= 1'b0;
        end else begin
            misaligned_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= CW'(LATENCY - 1);
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q          <= ST_DONE;
                        misaligned_err_q <= misalign;
                        if (rd_req) read_data_q <= misalign ? 32'h0 : load_data;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: busywait must rise in the request cycle itself, so it is decoded from state, not registered.
    assign bus.busywait       = rst & (((state_q == ST_IDLE) & req) | (state_q == ST_ACCESS));
    assign bus.read_data      = read_data_q;
    assign bus.misaligned_err = misaligned_err_q;
endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench for dmem_controller: table of accesses plus reset-abort and misalignment sequences.
module tb_dmem_controller;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 4;

    typedef struct {
        string       name;
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    logic [31:0] last_rd = 32'h0;
    vec_t vecs[$];
    sb_t  sb[$];

    dmem_if bus ();

    dmem_controller #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mem_read   = 4'b0;
        bus.mem_write  = 3'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
    endtask

    function automatic void add(input string name, input logic [3:0] rd, input logic [2:0] wr,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp, input logic exp_err);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr;
        v.wd = wd; v.exp = exp; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that ends the DONE cycle.
    task automatic apply(input vec_t v);
        int   busy_cnt;
        bit   done;
        sb_t  e;
        sb_t  got;
        bus.mem_read   = v.rd;
        bus.mem_write  = v.wr;
        bus.address    = v.addr;
        bus.write_data = v.wd;
        if (v.rd[3] && !v.wr[2]) last_rd = v.exp;
        e.rdata = last_rd;
        e.err   = v.exp_err;
        sb.push_back(e);
        busy_cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (i == 0) check({v.name, " err_idle"}, {31'h0, bus.misaligned_err}, 32'h0);
            if (bus.busywait) busy_cnt++;
            else done = 1'b1;
        end
        check({v.name, " stall"}, busy_cnt, LATENCY + 1);
        got = sb.pop_front();
        check({v.name, " rdata"}, bus.read_data, got.rdata);
        check({v.name, " err"}, {31'h0, bus.misaligned_err}, {31'h0, got.err});
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a request pending: busywait must stay low.
        idle_inputs();
        bus.mem_read = 4'b1010;
        repeat (2) @(negedge clk);
        check("busy_in_reset", {31'h0, bus.busywait}, 32'h0);
        idle_inputs();
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst busy", {31'h0, bus.busywait}, 32'h0);
        check("rst rdata", bus.read_data, 32'h0);
        check("rst err", {31'h0, bus.misaligned_err}, 32'h0);
        @(posedge clk);
        #1;

        add("SW 10",      4'b0000, 3'b110, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        add("LW 10",      4'b1010, 3'b000, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        add("LB 13",      4'b1000, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0);
        add("LBU 13",     4'b1100, 3'b000, 32'h13,  32'h0,        32'h000000DE, 1'b0);
        add("LH 12",      4'b1001, 3'b000, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0);
        add("LHU 12",     4'b1101, 3'b000, 32'h12,  32'h0,        32'h0000DEAD, 1'b0);
        add("LB 10",      4'b1000, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0);
        add("SB 11",      4'b0000, 3'b100, 32'h11,  32'hAAAAAA55, 32'h0,        1'b0);
        add("SH 12",      4'b0000, 3'b101, 32'h12,  32'hFFFF1234, 32'h0,        1'b0);
        add("LW 410",     4'b1010, 3'b000, 32'h410, 32'h0,        32'h123455EF, 1'b0);
        add("RW 20",      4'b1010, 3'b110, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0);
        add("LW 20",      4'b1010, 3'b000, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0);
        add("LB 21",      4'b1000, 3'b000, 32'h21,  32'h0,        32'hFFFFFFF0, 1'b0);
        add("LH 22",      4'b1001, 3'b000, 32'h22,  32'h0,        32'hFFFFCAFE, 1'b0);
        add("LBU 22",     4'b1100, 3'b000, 32'h22,  32'h0,        32'h000000FE, 1'b0);
        add("LHU 20",     4'b1101, 3'b000, 32'h20,  32'h0,        32'h0000F00D, 1'b0);
        add("F3_011 20",  4'b1011, 3'b000, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0);
        add("F3_111 10",  4'b1111, 3'b000, 32'h10,  32'h0,        32'h123455EF, 1'b0);
        foreach (vecs[i]) apply(vecs[i]);

        // Reset in cycle 2 of a store aborts it without committing.
        bus.mem_write  = 3'b110;
        bus.address    = 32'h10;
        bus.write_data = 32'h0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check("abort busy", {31'h0, bus.busywait}, 32'h0);
        check("abort rdata", bus.read_data, 32'h0);
        @(negedge clk);
        check("abort busy held", {31'h0, bus.busywait}, 32'h0);
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b1;
        last_rd = 32'h0;
        @(posedge clk);
        #1;
        vecs.delete();
        add("LW after abort", 4'b1010, 3'b000, 32'h10, 32'h0, 32'h123455EF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        add("LW 12 mis",  4'b1010, 3'b000, 32'h12, 32'h0,        32'h0,        1'b1);
        add("SH 11 mis",  4'b0000, 3'b101, 32'h11, 32'h00005678, 32'h0,        1'b1);
        add("LW 10 keep", 4'b1010, 3'b000, 32'h10, 32'h0,        32'h123455EF, 1'b0);
`else
        add("LW 12 force", 4'b1010, 3'b000, 32'h12, 32'h0,        32'h123455EF, 1'b0);
        add("SH 11 force", 4'b0000, 3'b101, 32'h11, 32'h00005678, 32'h0,        1'b0);
        add("LW 10 half",  4'b1010, 3'b000, 32'h10, 32'h0,        32'h12345678, 1'b0);
`endif
        foreach (vecs[i]) apply(vecs[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
